// File: rtl/cfg_serial_tx.sv
// Serial configuration transmitter: releases the backend reset, waits for its
// synchronised ready, then shifts one word MSB-first on o_sclk/o_sdout.
`timescale 1ns/1ps

module cfg_serial_tx #(
    parameter int unsigned WORD_W        = 16,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned READY_TIMEOUT = 256
) (
    input  logic              i_clk,
    input  logic              i_resetbALL,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_resetb_target,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_sclk,
    output logic              o_sdout
);

    localparam int unsigned RST_W = (RST_CYCLES > 1)    ? $clog2(RST_CYCLES)    : 1;
    localparam int unsigned TMO_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1)       ? $clog2(CLK_DIV)       : 1;
    localparam int unsigned BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_RST_HOLD,
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SHIFT
    } state_e;

    state_e            state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              phase_hi_q, phase_hi_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              rdy_meta_q, rdy_meta_d;
    logic              rdy_sync_q, rdy_sync_d;
    logic              resetb_q, resetb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              sclk_q, sclk_d;
    logic              sdout_q, sdout_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        phase_hi_d = phase_hi_q;
        shift_d    = shift_q;
        rdy_meta_d = i_ready;
        rdy_sync_d = rdy_meta_q;
        resetb_d   = resetb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sclk_d     = sclk_q;
        sdout_d    = sdout_q;

        case (state_q)
            ST_RST_HOLD: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    resetb_d  = 1'b1;
                    rst_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            // busy_q is still high for the one cycle after done/err; starts then are dropped
            ST_IDLE: begin
                busy_d = 1'b0;
                sclk_d = 1'b0;
                if (i_start && !busy_q && resetb_q) begin
                    shift_d   = i_data;
                    busy_d    = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_RDY;
                end
            end

            ST_WAIT_RDY: begin
                if (rdy_sync_q) begin
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    phase_hi_d = 1'b0;
                    sclk_d     = 1'b0;
                    sdout_d    = shift_q[WORD_W-1];
                    shift_d    = {shift_q[WORD_W-2:0], 1'b0};
                    state_d    = ST_SHIFT;
                end else if (tmo_cnt_q == TMO_W'(READY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            // Loss of ready takes priority over any bit or frame completion
            ST_SHIFT: begin
                if (!rdy_sync_q) begin
                    sclk_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    if (!phase_hi_q) begin
                        phase_hi_d = 1'b1;
                        sclk_d     = 1'b1;
                    end else if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                        phase_hi_d = 1'b0;
                        sclk_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        phase_hi_d = 1'b0;
                        sclk_d     = 1'b0;
                        sdout_d    = shift_q[WORD_W-1];
                        shift_d    = {shift_q[WORD_W-2:0], 1'b0};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            state_q    <= ST_RST_HOLD;
            rst_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            phase_hi_q <= 1'b0;
            shift_q    <= '0;
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
            resetb_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sclk_q     <= 1'b0;
            sdout_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_hi_q <= phase_hi_d;
            shift_q    <= shift_d;
            rdy_meta_q <= rdy_meta_d;
            rdy_sync_q <= rdy_sync_d;
            resetb_q   <= resetb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sclk_q     <= sclk_d;
            sdout_q    <= sdout_d;
        end
    end

    assign o_resetb_target = resetb_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_sclk          = sclk_q;
    assign o_sdout         = sdout_q;

endmodule
